// File: rtl/serial_adder_pkg.sv
// Shared types and limits for the bit-serial adder.
package serial_adder_pkg;

    typedef enum logic [1:0] {IDLE, RUN, DONE} sa_state_t;

    localparam int SA_MIN_WIDTH = 2;

endpackage

// File: rtl/serial_adder_full_adder.sv
// One-bit full adder assembled from two cascaded half-adder stages.
module full_adder_cell (
    input  logic a,
    input  logic b,
    input  logic ci,
    output logic s,
    output logic co
);

    logic p;
    logic g;

    assign p  = a ^ b;
    assign g  = a & b;
    assign s  = p ^ ci;
    assign co = g | (ci & p);

endmodule

// File: rtl/serial_adder.sv
// Bit-serial adder: one full-adder cell plus a carry flip-flop, LSB first,
// with valid/ready handshakes on both the operand and the result side.
module serial_adder
    import serial_adder_pkg::*;
#(
    parameter int WIDTH  = 8,
    parameter bit SIGNED = 1'b0
) (
    input  logic             clk,
    input  logic             rst,
    input  logic             in_valid,
    output logic             in_ready,
    input  logic [WIDTH-1:0] a,
    input  logic [WIDTH-1:0] b,
    input  logic             cin,
    output logic             out_valid,
    input  logic             out_ready,
    output logic [WIDTH-1:0] sum,
    output logic             cout,
    output logic             ovf
);

    localparam int CW = $clog2(WIDTH);

    if (WIDTH < SA_MIN_WIDTH) begin : g_width_check
        $error("serial_adder: WIDTH must be at least %0d", SA_MIN_WIDTH);
    end

    sa_state_t         state;
    sa_state_t         state_n;
    logic [CW-1:0]     count;
    logic [WIDTH-1:0]  a_sh;
    logic [WIDTH-1:0]  b_sh;
    logic              carry;
    logic              fa_s;
    logic              fa_c;
    logic              last;

    full_adder_cell u_fa (
        .a  (a_sh[0]),
        .b  (b_sh[0]),
        .ci (carry),
        .s  (fa_s),
        .co (fa_c)
    );

    assign last      = (count == CW'(WIDTH - 1));
    assign in_ready  = (state == IDLE) && !rst;
    assign out_valid = (state == DONE);

    always_ff @(posedge clk) begin
        if (rst) begin
            state <= IDLE;
        end else begin
            state <= state_n;
        end
    end

    always_comb begin
        state_n = state;
        case (state)
            IDLE:    if (in_valid) state_n = RUN;
            RUN:     if (last) state_n = DONE;
            DONE:    if (out_ready) state_n = IDLE;
            default: state_n = IDLE;
        endcase
    end

    // Sum fills from the MSB end, so after WIDTH shifts bit 0 holds the first result bit.
    always_ff @(posedge clk) begin
        if (rst) begin
            sum   <= '0;
            cout  <= 1'b0;
            ovf   <= 1'b0;
            count <= '0;
            carry <= 1'b0;
            a_sh  <= '0;
            b_sh  <= '0;
        end else begin
            case (state)
                IDLE: begin
                    if (in_valid) begin
                        a_sh  <= a;
                        b_sh  <= b;
                        carry <= cin;
                        count <= '0;
                    end
                end
                RUN: begin
                    a_sh  <= a_sh >> 1;
                    b_sh  <= b_sh >> 1;
                    sum   <= {fa_s, sum[WIDTH-1:1]};
                    carry <= fa_c;
                    count <= count + CW'(1);
                    if (last) begin
                        cout <= fa_c;
                        // carry here is still the carry into the MSB
                        ovf  <= SIGNED ? (carry ^ fa_c) : 1'b0;
                    end
                end
                default: ;
            endcase
        end
    end

endmodule
